// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline flow controller.
package pipe_ctrl_pkg;

    localparam int NUM_STAGES_DEF     = 5;
    localparam int REDIRECT_STAGE_DEF = 2;
    localparam int MC_LAT_W_DEF       = 4;
    localparam int CNT_W_DEF          = 32;

    // Named stage indices for the default 5-stage layout
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // One increment strobe per performance counter
    typedef struct packed {
        logic cycle;
        logic retire;
        logic stall;
        logic flush;
    } perf_inc_t;

endpackage

// File: rtl/pipe_mc_timer.sv
// Multi-cycle op hold timer: holds the redirect stage for L cycles, then
// remembers completion until that instruction leaves the stage.
module pipe_mc_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LAT_W = MC_LAT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MC_LAT_W-1:0] lat,
    input  logic                valid,
    input  logic                advance,
    output logic                hold
);

    logic [MC_LAT_W-1:0] r_cnt;
    logic                r_done;
    logic                w_trig;

    // New op only when idle and not already serviced for this instruction
    assign w_trig = start & valid & ~r_done & (lat != '0) & (r_cnt == '0);
    assign hold   = w_trig | (r_cnt != '0);

    // Countdown and done flag; done is set in the last hold cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            if (r_cnt != '0)
                r_cnt <= r_cnt - MC_LAT_W'(1);
            else if (w_trig)
                r_cnt <= lat - MC_LAT_W'(1);

            if ((r_cnt == MC_LAT_W'(1)) || (w_trig && (lat == MC_LAT_W'(1))))
                r_done <= 1'b1;
            else if (advance)
                r_done <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Central stall/flush/valid controller for an N-stage in-order pipeline.
module pipeline_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = NUM_STAGES_DEF,
    parameter int REDIRECT_STAGE = REDIRECT_STAGE_DEF,
    parameter int MC_LAT_W       = MC_LAT_W_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_valid_i,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic                  redirect_i,
    input  logic                  mc_start_i,
    input  logic [MC_LAT_W-1:0]   mc_lat_i,
    output logic                  pc_en_o,
    output logic [NUM_STAGES-1:0] stage_en_o,
    output logic [NUM_STAGES-1:0] stage_flush_o,
    output logic [NUM_STAGES-1:0] stage_valid_o,
    output logic                  mc_busy_o,
    output logic                  retire_o,
    output logic [CNT_W-1:0]      perf_cycles_o,
    output logic [CNT_W-1:0]      perf_retired_o,
    output logic [CNT_W-1:0]      perf_stall_o,
    output logic [CNT_W-1:0]      perf_flush_o
);

    localparam int R = REDIRECT_STAGE;

    logic [NUM_STAGES-1:1] r_valid;
    logic [NUM_STAGES-1:0] w_v;
    logic [NUM_STAGES-1:0] w_req_hi;
    logic [NUM_STAGES-1:0] w_eff;
    logic [NUM_STAGES-1:0] w_held;
    logic [NUM_STAGES-1:0] w_en;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_mc_hold;
    logic                  w_redir_acc;
    logic                  w_pc_en;
    logic                  w_advance;
    perf_inc_t             w_inc;
    logic [CNT_W-1:0]      r_cycles, r_retired, r_stall, r_flush;

    assign w_v = {r_valid, fetch_valid_i};

    // Requests at or below the redirect stage; these decide whether the redirect is taken
    always_comb begin
        w_req_hi = '0;
        for (int s = R; s < NUM_STAGES; s++)
            w_req_hi[s] = (stall_req_i[s] & w_v[s]) | ((s == R) & w_mc_hold);
    end

    assign w_redir_acc = redirect_i & w_v[R] & ~(|w_req_hi);

    // Younger-stage requests are masked by an accepted redirect
    always_comb begin
        w_eff = w_req_hi;
        for (int s = 0; s < R; s++)
            w_eff[s] = stall_req_i[s] & w_v[s] & ~w_redir_acc;
    end

    assign w_pc_en = ~w_held[0] | w_redir_acc;

    genvar gs;
    generate
        for (gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
            // A hold anywhere downstream freezes this stage too
            assign w_held[gs] = |(w_eff >> gs);
            if (gs == STG_IF) begin : g_fetch
                assign w_en[gs]    = w_pc_en;
                assign w_flush[gs] = 1'b0;
            end else begin : g_body
                assign w_en[gs]    = ~w_held[gs];
                assign w_flush[gs] = w_en[gs] & (w_held[gs-1] | (w_redir_acc & (gs <= R)));
            end
        end
    endgenerate

    // Per-stage valid: hold, insert bubble, or take the upstream valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (!w_held[s])
                    r_valid[s] <= w_flush[s] ? 1'b0 : w_v[s-1];
            end
        end
    end

    assign w_advance = w_en[R+1] & ~w_held[R];

    pipe_mc_timer #(.MC_LAT_W(MC_LAT_W)) u_mc_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (mc_start_i),
        .lat     (mc_lat_i),
        .valid   (w_v[R]),
        .advance (w_advance),
        .hold    (w_mc_hold)
    );

    assign w_inc.cycle  = 1'b1;
    assign w_inc.retire = r_valid[NUM_STAGES-1];
    assign w_inc.stall  = w_held[0];
    assign w_inc.flush  = w_redir_acc;

    // Free-running performance counters, wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles  <= '0;
            r_retired <= '0;
            r_stall   <= '0;
            r_flush   <= '0;
        end else begin
            r_cycles  <= r_cycles  + CNT_W'(w_inc.cycle);
            r_retired <= r_retired + CNT_W'(w_inc.retire);
            r_stall   <= r_stall   + CNT_W'(w_inc.stall);
            r_flush   <= r_flush   + CNT_W'(w_inc.flush);
        end
    end

    assign pc_en_o        = w_pc_en;
    assign stage_en_o     = w_en;
    assign stage_flush_o  = w_flush;
    assign stage_valid_o  = w_v;
    assign mc_busy_o      = w_mc_hold;
    assign retire_o       = r_valid[NUM_STAGES-1];
    assign perf_cycles_o  = r_cycles;
    assign perf_retired_o = r_retired;
    assign perf_stall_o   = r_stall;
    assign perf_flush_o   = r_flush;

endmodule

// File: doc/pipeline_flow_ctrl.md
Name: pipeline_flow_ctrl

Overview:
- Parametrised central stall/flush/valid controller for an N-stage in-order pipeline.
- Generalises fixed 5-stage if/id/ex/mem/wb control to NUM_STAGES stages with:
  - per-stage valid tracking and per-stage stall requests;
  - redirect flush from a configurable stage;
  - a multi-cycle-op hold timer;
  - performance counters.
- Sits beside the stage instances. Drives the enable and flush inputs of every inter-stage register and of the PC.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0 = fetch, stage NUM_STAGES-1 = writeback; legal range 3..8
REDIRECT_STAGE, 2, stage that resolves branches/jumps; legal range 1..NUM_STAGES-2
MC_LAT_W, 4, width of multi-cycle latency input
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_valid_i  in  1  stage 0 holds a real instruction this cycle
stall_req_i  in  NUM_STAGES  per-stage hold request (e.g. load-use at stage 1)
redirect_i  in  1  REDIRECT_STAGE requests control-flow redirect
mc_start_i  in  1  instruction in REDIRECT_STAGE is multi-cycle
mc_lat_i  in  MC_LAT_W  extra hold cycles for that instruction
pc_en_o  out  1  PC register loads this cycle
stage_en_o  out  NUM_STAGES  bit s (s>=1): register feeding stage s loads; bit 0 mirrors pc_en_o
stage_flush_o  out  NUM_STAGES  bit s: register feeding stage s loads a bubble; bit 0 always 0
stage_valid_o  out  NUM_STAGES  valid of instruction currently in each stage; bit 0 = fetch_valid_i
mc_busy_o  out  1  multi-cycle hold active
retire_o  out  1  stage NUM_STAGES-1 valid this cycle
perf_cycles_o  out  CNT_W  cycles since reset
perf_retired_o  out  CNT_W  retired instructions
perf_stall_o  out  CNT_W  cycles with any stage held
perf_flush_o  out  CNT_W  accepted redirects

Behaviour:
- Reset (synchronous):
  - valid[1..N-1]=0, mc counter=0, mc_done=0, all perf counters=0.
  - During and after reset all outputs are derived from the cleared state: stage_valid_o[N-1:1]=0, retire_o=0, mc_busy_o=0, stage_flush_o=0.
- Internal state is valid[s] for s>=1; v[0]=fetch_valid_i.
- mc_hold = (mc_start_i & v[R] & ~mc_done & mc_lat_i!=0) | (cnt!=0).
- redirect_acc = redirect_i & v[R] & ~held[R]. A redirect while stage R is held is ignored.
- eff_req[s] = stall_req_i[s] & v[s] & ~(redirect_acc & s<R) | (s==R & mc_hold). Requests from invalid stages are ignored.
- held[s] = OR of eff_req[k] for k>=s (hold propagates upstream, combinational).
- Outputs:
  - pc_en_o = ~held[0] | redirect_acc.
  - stage_en_o[s] = ~held[s].
  - stage_flush_o[s] = stage_en_o[s] & (held[s-1] | (redirect_acc & s<=R)).
- valid update, s>=1:
  - if held[s]: hold;
  - elif flush[s]: 0;
  - else valid[s-1].
- Multi-cycle timer:
  - Start cycle t with latency L>=1: cnt loads L-1 and stage R is held for cycles t..t+L-1.
  - At end of cycle t+L-1 mc_done is set, so a persisting mc_start_i is not re-triggered.
  - mc_done clears when stage R advances (en[R+1] with held[R]=0).
  - L=0: no hold. mc_start_i is ignored while cnt!=0 or mc_done.
- mc_busy_o = mc_hold.
- The last stage is never held by downstream; stall_req_i[N-1] is legal and holds it.
- Counters increment by 1 and wrap modulo 2^CNT_W:
  - perf_cycles every non-reset cycle;
  - perf_retired on retire_o;
  - perf_stall when held[0];
  - perf_flush on redirect_acc.
- Simultaneous stall_req at stage s<R and redirect_acc: the redirect wins and the younger stalls are masked.
- Simultaneous stall_req at stage s>R and redirect: redirect_acc=0, because held[R]=1.
- Reset asserted mid multi-cycle op or mid stall: everything clears next edge.

Decomposition:
- Package pipe_ctrl_pkg: default NUM_STAGES/REDIRECT_STAGE constants, named stage indices (STG_IF..STG_WB), perf counter struct type.
- One sub-module pipe_mc_timer: counter, mc_done, mc_hold, with inputs start, lat, valid, advance.

Test Plan:
1. Reset, then fetch_valid_i=1 for 10 cycles, no requests -> stage_valid_o fills one bit per cycle; retire_o first high at cycle 4; perf_retired_o=6 after 10 cycles; stage_flush_o=0 throughout.
2. stall_req_i[1]=1 for one cycle with v[1]=1 -> pc_en_o=0, stage_en_o[1]=0, stage_flush_o[2]=1; next cycle stage_valid_o[2]=0; perf_stall_o increments by 1.
3. redirect_i=1 with v[2]=1 and simultaneous stall_req_i[1]=1 -> pc_en_o=1, stage_flush_o[1]=stage_flush_o[2]=1; next cycle stage_valid_o[1]=stage_valid_o[2]=0, stage_valid_o[3]=1; perf_flush_o=1.
4. mc_start_i=1, mc_lat_i=3, held for 5 cycles -> mc_busy_o high exactly 3 cycles; stage R advances in the 4th cycle; no re-trigger; stage_flush_o[3]=1 during the 3 hold cycles.
5. mc_lat_i=3 busy, plus redirect_i during the hold -> redirect ignored, perf_flush_o unchanged.
6. Reset asserted while cnt=2 and stall active -> next cycle mc_busy_o=0, all valids 0, counters 0; invalid-stage stall_req_i[3] with v[3]=0 -> no hold.
